// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32/64 M-extension execute unit.
//
// Sits beside the ALU in EX. An instruction is taken when the unit is idle,
// i_valid is high, i_alu_op selects the mul/div class, funct7 bit 0 is set
// and no flush is in progress. Multiplies use a one-bit-per-cycle shift-add
// on operand magnitudes; divides use a one-bit-per-cycle restoring divider.
// Divide-by-zero and signed overflow skip the iteration and finish at once.
//
// Ports:
//   i_clk, i_rst       clock (rising edge), asynchronous active-high reset
//   i_valid            EX-stage instruction valid
//   i_alu_op           ALU op class from the main decoder
//   i_funct_3          instruction funct3 (selects one of the eight M ops)
//   i_funct_7_0        funct7 bit 0 (M-extension select)
//   i_rs1, i_rs2       operands A and B
//   i_flush            pipeline flush, aborts any operation
//   o_busy             stall request while an accepted op is in flight
//   o_valid            single-cycle result strobe
//   o_result           result, held until the next o_valid
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [2:0]      i_alu_op,
  input  logic [2:0]      i_funct_3,
  input  logic            i_funct_7_0,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam logic [2:0]       OP_MULDIV = 3'b101;
  localparam logic [2:0]       F3_MUL    = 3'b000;
  localparam logic [2:0]       F3_MULH   = 3'b001;
  localparam logic [2:0]       F3_MULHSU = 3'b010;
  localparam logic [2:0]       F3_DIV    = 3'b100;
  localparam logic [2:0]       F3_REM    = 3'b110;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(XLEN);
  localparam logic [XLEN-1:0]  XLEN_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  count_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] opB_q;
  logic [XLEN-1:0]   opA_q;
  logic [XLEN-1:0]   result_q;
  logic [2:0]        funct_q;
  logic              negQ_q;
  logic              negR_q;

  logic              accept;
  logic              aSigned, bSigned, signA, signB;
  logic [XLEN-1:0]   magA, magB;
  logic              divZero, divOvf, special;
  logic [XLEN-1:0]   specialResult;
  logic [2*XLEN-1:0] mulSum;
  logic [XLEN:0]     remShift, divisorExt, remNext;
  logic              qBit;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quotient, remainder, finalResult;

  // Decode of the incoming instruction: acceptance, operand magnitudes and
  // the early-out cases that need no iteration. Acc/opA/opB hold the
  // product/multiplier/multiplicand for multiplies and the partial
  // remainder/dividend-quotient/divisor for divides.
  always_comb begin
    accept  = (state_q == IDLE) & i_valid & (i_alu_op == OP_MULDIV) &
              i_funct_7_0 & ~i_flush;
    aSigned = (i_funct_3 == F3_MUL) | (i_funct_3 == F3_MULH) |
              (i_funct_3 == F3_MULHSU) | (i_funct_3 == F3_DIV) |
              (i_funct_3 == F3_REM);
    bSigned = (i_funct_3 == F3_MUL) | (i_funct_3 == F3_MULH) |
              (i_funct_3 == F3_DIV) | (i_funct_3 == F3_REM);
    signA   = aSigned & i_rs1[XLEN-1];
    signB   = bSigned & i_rs2[XLEN-1];
    magA    = signA ? -i_rs1 : i_rs1;
    magB    = signB ? -i_rs2 : i_rs2;
    divZero = i_funct_3[2] & (i_rs2 == '0);
    divOvf  = i_funct_3[2] & ~i_funct_3[0] & (i_rs1 == XLEN_MIN) & (i_rs2 == '1);
    special = divZero | divOvf;
    // funct3[1] distinguishes REM/REMU from DIV/DIVU
    if (divZero) begin
      specialResult = i_funct_3[1] ? i_rs1 : '1;
    end else begin
      specialResult = i_funct_3[1] ? '0 : i_rs1;
    end
  end

  // One iteration of each datapath plus the sign fix-up applied on the
  // final CALC cycle.
  always_comb begin
    mulSum      = acc_q + (opA_q[0] ? opB_q : '0);
    remShift    = {acc_q[XLEN-1:0], opA_q[XLEN-1]};
    divisorExt  = {1'b0, opB_q[XLEN-1:0]};
    qBit        = (remShift >= divisorExt);
    remNext     = qBit ? (remShift - divisorExt) : remShift;
    product     = negQ_q ? -acc_q : acc_q;
    quotient    = negQ_q ? -opA_q : opA_q;
    remainder   = negR_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    finalResult = product[2*XLEN-1:XLEN];
    if (funct_q == F3_MUL) begin
      finalResult = product[XLEN-1:0];
    end else if (funct_q[2] & ~funct_q[1]) begin
      finalResult = quotient;
    end else if (funct_q[2] & funct_q[1]) begin
      finalResult = remainder;
    end
  end

  // Control FSM and datapath registers. The counter runs 0..XLEN in CALC:
  // XLEN iteration cycles followed by one cycle that registers the result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      opB_q    <= '0;
      opA_q    <= '0;
      result_q <= '0;
      funct_q  <= '0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            funct_q <= i_funct_3;
            negQ_q  <= signA ^ signB;
            negR_q  <= signA;
            count_q <= '0;
            acc_q   <= '0;
            if (special) begin
              result_q <= specialResult;
              state_q  <= DONE;
            end else begin
              state_q <= CALC;
              if (i_funct_3[2]) begin
                opA_q <= magA;
                opB_q <= {{XLEN{1'b0}}, magB};
              end else begin
                opA_q <= magB;
                opB_q <= {{XLEN{1'b0}}, magA};
              end
            end
          end
        end
        CALC: begin
          if (i_flush) begin
            state_q <= IDLE;
            count_q <= '0;
          end else if (count_q == CNT_LAST) begin
            result_q <= finalResult;
            state_q  <= DONE;
          end else begin
            count_q <= count_q + 1'b1;
            if (funct_q[2]) begin
              acc_q <= {{(XLEN-1){1'b0}}, remNext};
              opA_q <= {opA_q[XLEN-2:0], qBit};
            end else begin
              acc_q <= mulSum;
              opB_q <= opB_q << 1;
              opA_q <= opA_q >> 1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // A flush arriving in the DONE cycle cancels the strobe that cycle.
  assign o_busy   = (state_q == CALC) | accept;
  assign o_valid  = (state_q == DONE) & ~i_flush;
  assign o_result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            inValid = 1'b0;
  logic [2:0]      aluOp = 3'b000;
  logic [2:0]      funct3 = 3'b000;
  logic            funct70 = 1'b0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            flush = 1'b0;
  logic            busy;
  logic            outValid;
  logic [XLEN-1:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_valid     (inValid),
    .i_alu_op    (aluOp),
    .i_funct_3   (funct3),
    .i_funct_7_0 (funct70),
    .i_rs1       (rs1),
    .i_rs2       (rs2),
    .i_flush     (flush),
    .o_busy      (busy),
    .o_valid     (outValid),
    .o_result    (result)
  );

  always #5 clock = ~clock;

  // Golden arithmetic for the eight M operations, straight from the ISA rules.
  function automatic logic [31:0] golden(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    golden = '0;
    case (f)
      3'd0: golden = a * b;
      3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); golden = sp[63:32]; end
      3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); golden = sp[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; golden = up[63:32]; end
      3'd4: if (b == 0) golden = '1;
            else if (a == 32'h8000_0000 && b == '1) golden = a;
            else golden = sa / sb;
      3'd5: golden = (b == 0) ? '1 : a / b;
      3'd6: if (b == 0) golden = a;
            else if (a == 32'h8000_0000 && b == '1) golden = '0;
            else golden = sa % sb;
      default: golden = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit isSpecial(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == '1));
  endfunction

  // Cycle-level model: an op finishes XLEN+1 edges after acceptance, or on the
  // accept edge itself for the early-out cases.
  bit              mBusy = 0;
  bit              mValid = 0;
  int              mLeft = 0;
  logic [XLEN-1:0] mPending = '0;
  logic [XLEN-1:0] mResult = '0;

  function automatic bit acceptCond();
    return !mBusy && !mValid && inValid && aluOp == 3'b101 && funct70 && !flush;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mBusy = 0; mValid = 0; mLeft = 0; mResult = '0;
    end else if (mValid) begin
      mValid = 0;
    end else if (mBusy) begin
      if (flush) mBusy = 0;
      else if (mLeft == 1) begin mBusy = 0; mValid = 1; mResult = mPending; end
      else mLeft--;
    end else if (acceptCond()) begin
      if (isSpecial(funct3, rs1, rs2)) begin
        mValid = 1; mResult = golden(funct3, rs1, rs2);
      end else begin
        mBusy = 1; mLeft = XLEN + 1; mPending = golden(funct3, rs1, rs2);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Every cycle the outputs are compared with the model.
  always @(negedge clock) begin
    checkOutput("model busy", {31'b0, busy}, {31'b0, mBusy || acceptCond()});
    checkOutput("model valid", {31'b0, outValid}, {31'b0, mValid && !flush});
    checkOutput("model result", result, mResult);
  end

  task automatic applyStimulus(input bit v, input bit f7, input logic [2:0] f,
                               input logic [31:0] a, input logic [31:0] b, input bit fl);
    inValid = v; aluOp = 3'b101; funct70 = f7; funct3 = f; rs1 = a; rs2 = b; flush = fl;
  endtask

  // Issue one op in the current cycle, wait for the strobe and check the
  // literal result, the strobe edge and the number of stall cycles after accept.
  task automatic runOp(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expRes, input int expEdge);
    int  edgeIdx;
    int  busyCnt;
    bit  seen;
    edgeIdx = 0; busyCnt = 0; seen = 0;
    applyStimulus(1, 1, f, a, b, 0);
    @(posedge clock); #1;
    inValid = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (outValid) begin seen = 1; break; end
      if (busy) busyCnt++;
      @(posedge clock); #1;
      edgeIdx++;
    end
    checkOutput({name, " seen"}, {31'b0, seen}, 32'd1);
    checkOutput({name, " edge"}, edgeIdx, expEdge);
    checkOutput({name, " busy cycles"}, busyCnt, expEdge);
    checkOutput({name, " result"}, result, expRes);
    @(posedge clock); #1;
  endtask

  initial begin
    int seenValid;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset valid", {31'b0, outValid}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    reset = 0;
    @(posedge clock); #1;

    runOp("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, XLEN + 1);
    runOp("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, XLEN + 1);
    runOp("MULH", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, XLEN + 1);
    runOp("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, XLEN + 1);
    runOp("MULH big", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, XLEN + 1);
    runOp("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, XLEN + 1);
    runOp("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, XLEN + 1);
    runOp("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, XLEN + 1);
    runOp("REMU 100/7", 3'd7, 32'd100, 32'd7, 32'd2, XLEN + 1);
    runOp("DIVU big", 3'd5, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, XLEN + 1);
    runOp("DIVU by 0", 3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 0);
    runOp("REM by 0", 3'd6, 32'h1234, 32'd0, 32'h1234, 0);
    runOp("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);

    // Flush ten cycles into a divide: no strobe, result keeps the previous value.
    applyStimulus(1, 1, 3'd4, 32'd100, 32'd7, 0);
    @(posedge clock); #1;
    inValid = 0;
    repeat (10) begin @(posedge clock); #1; end
    flush = 1;
    @(posedge clock); #1;
    flush = 0;
    @(negedge clock);
    checkOutput("flush idle busy", {31'b0, busy}, 32'd0);
    seenValid = 0;
    repeat (40) begin @(negedge clock); if (outValid) seenValid++; end
    checkOutput("flush no valid", seenValid, 0);
    checkOutput("flush result held", result, 32'h8000_0000);
    @(posedge clock); #1;

    runOp("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);

    // Flush and accept in the same cycle: nothing starts.
    applyStimulus(1, 1, 3'd0, 32'd5, 32'd5, 1);
    @(negedge clock);
    checkOutput("flush+accept busy", {31'b0, busy}, 32'd0);
    @(posedge clock); #1;
    applyStimulus(0, 1, 3'd0, 32'd5, 32'd5, 0);
    @(negedge clock);
    checkOutput("flush+accept idle", {31'b0, busy}, 32'd0);
    @(posedge clock); #1;

    // funct7 bit 0 clear: not an M instruction.
    applyStimulus(1, 0, 3'd0, 32'd5, 32'd5, 0);
    @(negedge clock);
    checkOutput("funct7 busy", {31'b0, busy}, 32'd0);
    @(posedge clock); #1;
    inValid = 0;
    @(negedge clock);
    checkOutput("funct7 idle", {31'b0, busy}, 32'd0);
    @(posedge clock); #1;

    // Reset five cycles into a multiply.
    applyStimulus(1, 1, 3'd0, 32'd5, 32'd6, 0);
    @(posedge clock); #1;
    inValid = 0;
    repeat (5) begin @(posedge clock); #1; end
    reset = 1;
    #1;
    checkOutput("midreset busy", {31'b0, busy}, 32'd0);
    checkOutput("midreset valid", {31'b0, outValid}, 32'd0);
    checkOutput("midreset result", result, 32'd0);
    @(posedge clock); #1;
    reset = 0;
    @(posedge clock); #1;
    runOp("MUL 3*4", 3'd0, 32'd3, 32'd4, 32'd12, XLEN + 1);
    runOp("MUL back2back", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, XLEN + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no end expected end");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative RV M-extension execute unit. It sits beside the ALU in the EX stage and is selected by the ALU decode field (i_alu_op == OP_MULDIV = 3'b101, funct7 bit 0 set).
- Decodes funct3 into the eight M operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Computes the result with a one-bit-per-cycle shift-add multiplier or a restoring divider.
- Signals the hazard unit through a valid/busy handshake so the pipeline can stall.

Parameters:
- XLEN, 32, operand and result width; legal values 8..64.
- CNT_W, $clog2(XLEN+1), iteration counter width; derived, never overridden.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_valid  input  1  EX-stage instruction valid
- i_alu_op  input  3  ALU op class from the main decoder
- i_funct_3  input  3  instruction funct3
- i_funct_7_0  input  1  funct7 bit 0 (M-extension select)
- i_rs1  input  XLEN  operand A
- i_rs2  input  XLEN  operand B
- i_flush  input  1  pipeline flush; aborts any operation
- o_busy  output  1  high while an accepted operation has not yet produced its result (stall request)
- o_valid  output  1  single-cycle result strobe
- o_result  output  XLEN  result; held until the next o_valid

Behaviour:
- Reset (async, i_rst=1): state=IDLE, counter=0, all datapath registers=0, o_busy=0, o_valid=0, o_result=0. Reset mid-operation discards the operation with no o_valid.
- Accept condition: state==IDLE & i_valid & i_alu_op==3'b101 & i_funct_7_0 & !i_flush. On accept, latch the operands, op code, and sign-fix flags.
- While busy, i_valid/operands are ignored. The pipeline must hold EX stable until o_valid.
- FSM states:
  - IDLE -> CALC on a normal accept.
  - IDLE -> DONE on a special-case accept (see special cases).
  - CALC -> DONE when the counter reaches XLEN.
  - DONE -> IDLE unconditionally.
- o_busy = (state==CALC) | (accept this cycle, combinational).
- o_valid = (state==DONE). o_result is registered on the CALC->DONE or IDLE->DONE edge.
- Latency: normal ops give o_valid during the cycle after edge XLEN+1 (counting the accept edge as edge 0). Special cases give o_valid one cycle after accept.
- Multiply:
  - Operand magnitudes are formed per op: MUL/MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU both unsigned.
  - A 2*XLEN product is built by shift-add, one multiplier bit per CALC cycle.
  - The product is negated at the end if the sign flag is set.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
- Divide:
  - Restoring division on magnitudes, one quotient bit per CALC cycle.
  - Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1). Signed forms only.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases (no CALC; go straight to DONE):
  - Divide by zero: quotient=all ones, remainder=rs1 (signed and unsigned).
  - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1, DIV/REM): quotient=rs1, remainder=0.
- Flush:
  - i_flush in CALC or DONE forces IDLE next edge, suppresses o_valid, and leaves o_result unchanged.
  - Flush in the same cycle as an accept condition: flush wins, nothing is accepted.
- i_alu_op==3'b101 with i_funct_7_0=0 is not accepted; the unit stays IDLE.
- Back-to-back operations: a new accept is possible in the cycle after DONE, i.e. the first IDLE cycle.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), XLEN=32 -> o_busy high 33 cycles, o_valid at edge 33 after accept, o_result=0xFFFFFFEB.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 0x1234/0 -> 0xFFFFFFFF one cycle after accept. REM 0x1234/0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- Start DIV, assert i_flush on CALC cycle 10 -> state IDLE next cycle, no o_valid, o_result unchanged. Flush plus accept in the same cycle -> no start.
- Assert i_rst on CALC cycle 5 -> o_busy/o_valid/o_result=0 immediately. After release, MUL 3*4 -> 12 with normal latency.
